// File: rtl/soc_uart_pkg.sv
// Shared UART definitions for the SOC transmitter and receiver.
// Holds frame constants and the receiver state encoding.
package soc_uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// RXD synchronizer: two metastability flops, a third for edge history,
// and a registered falling-edge pulse. Flops reset to the idle level.
module uart_rx_sync
  import soc_uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic line,
  output logic fall
);

  logic [2:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= {3{UART_IDLE_LEVEL}};
      fall <= 1'b0;
    end else begin
      sr   <= {sr[1:0], rxd};
      fall <= sr[2] & ~sr[1];
    end
  end

  assign line = sr[2];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready output and sticky overrun flag.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data.
module uart_rx
  import soc_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      RXD,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      rx_busy,
  output logic                      rx_frame_err,
  output logic                      rx_parity_err,
  output logic                      rx_overrun
);

  localparam int DIV  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  localparam logic [CW-1:0] LD_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] LD_FULL = CW'(DIV - 1);
  localparam logic [2:0]    LAST    = 3'(UART_DATA_BITS - 1);

  if (DIV < 4) begin : g_div_check
    $error("uart_rx: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
  end

  logic line;
  logic fall;

  uart_rx_sync u_sync (
    .clk  (CLK),
    .rst  (RESET),
    .rxd  (RXD),
    .line (line),
    .fall (fall)
  );

  uart_rx_state_t            state, state_n;
  logic [CW-1:0]             cnt, cnt_n;
  logic [2:0]                idx, idx_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n;
  logic                      sample;
  logic                      deliver;
  logic                      frame_err_n;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad, par_bad_n;
  logic                      parity_err_n;
`endif

  assign sample  = (cnt == '0);
  assign rx_busy = (state != RX_IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt - CW'(1);
    idx_n        = idx;
    shreg_n      = shreg;
    deliver      = 1'b0;
    frame_err_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n    = par_bad;
    parity_err_n = 1'b0;
`endif
    unique case (state)
      RX_IDLE: begin
        cnt_n = cnt;
        if (fall) begin
          state_n = RX_START;
          cnt_n   = LD_HALF;
        end
      end
      RX_START: if (sample) begin
        // a start bit that is high again at mid-bit was only a glitch
        if (line == UART_IDLE_LEVEL) begin
          state_n = RX_IDLE;
        end else begin
          state_n = RX_DATA;
          cnt_n   = LD_FULL;
          idx_n   = '0;
        end
      end
      RX_DATA: if (sample) begin
        shreg_n = {line, shreg[UART_DATA_BITS-1:1]};
        cnt_n   = LD_FULL;
        idx_n   = idx + 3'd1;
        if (idx == LAST) begin
`ifdef UART_RX_PARITY_EN
          state_n = RX_PARITY;
`else
          state_n = RX_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: if (sample) begin
        par_bad_n = line ^ (^shreg);
        cnt_n     = LD_FULL;
        state_n   = RX_STOP;
      end
`endif
      RX_STOP: if (sample) begin
        state_n = RX_IDLE;
        if (line != UART_IDLE_LEVEL) begin
          frame_err_n = 1'b1;
`ifdef UART_RX_PARITY_EN
        end else if (par_bad) begin
          parity_err_n = 1'b1;
`endif
        end else begin
          deliver = 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  logic xfer;
  assign xfer = rx_valid & rx_ready;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= frame_err_n;
      // a byte lands only if the holding register is free this cycle
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (xfer) begin
        rx_valid <= 1'b0;
      end
      if (deliver && rx_valid && !rx_ready) begin
        rx_overrun <= 1'b1;
      end else if (xfer) begin
        rx_overrun <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_parity_err <= 1'b0;
    end else begin
      rx_parity_err <= parity_err_n;
    end
  end
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames
// compared against a bit-level frame model with fixed delivery latency.
module tb_uart_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int HALF   = DIV / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LAT = 3 + HALF + (NB - 1) * DIV;

  logic       CLK;
  logic       RESET;
  logic       RXD;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_overrun;

  uart_rx #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .RXD           (RXD),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_busy       (rx_busy),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_overrun    (rx_overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_xfer = 0;
  int         n_ferr = 0;
  int         n_perr = 0;
  int         rise_cyc = 0;
  int         ferr_cyc = 0;
  logic [7:0] xfer_data = '0;
  logic       v_prev = 1'b0;

  always begin
    @(negedge CLK);
    #1;
    if (rx_valid && rx_ready) begin
      n_xfer++;
      xfer_data = rx_data;
    end
    if (rx_valid && !v_prev) rise_cyc = cyc;
    v_prev = rx_valid;
    if (rx_frame_err) begin
      n_ferr++;
      ferr_cyc = cyc;
    end
    if (rx_parity_err) n_perr++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b,
                                        input logic stop,
                                        input logic pflip);
    logic [10:0] f;
    logic        par;
    par    = (^b) ^ pflip;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_RX_PARITY_EN
    f[9]   = par;
    f[10]  = stop;
`else
    f[9]   = stop;
    f[10]  = par;
`endif
    return f;
  endfunction

  // called on a negedge; t0 is the first edge that sees the start bit
  task automatic send(input logic [7:0] b, input logic stop,
                      input logic pflip, output int t0);
    logic [10:0] f;
    f  = frame(b, stop, pflip);
    t0 = cyc + 1;
    for (int i = 0; i < NB; i++) begin
      RXD = f[i];
      repeat (DIV) @(negedge CLK);
    end
    RXD = 1'b1;
  endtask

  int          t0;
  int          xb;
  int          fb;
  int          pb;
  int          gap;
  logic [7:0]  b;
  logic        good;
  logic [10:0] fr;

  initial begin
    RESET    = 1'b1;
    RXD      = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_ferr", rx_frame_err, 0);
    chk("rst_perr", rx_parity_err, 0);
    chk("rst_ovr", rx_overrun, 0);
    RESET = 1'b0;
    repeat (5) @(negedge CLK);

    xb = n_xfer; fb = n_ferr; pb = n_perr;
    send(8'h55, 1'b1, 1'b0, t0);
    repeat (2) @(negedge CLK);
    chk("single_cnt", n_xfer - xb, 1);
    chk("single_data", xfer_data, 8'h55);
    chk("single_lat", rise_cyc - t0, LAT);
    chk("single_ferr", n_ferr - fb, 0);
    chk("single_perr", n_perr - pb, 0);
    chk("single_ovr", rx_overrun, 0);
    chk("single_vlow", rx_valid, 0);

    xb = n_xfer; fb = n_ferr;
    t0 = cyc + 1;
    RXD = 1'b0;
    repeat (3) @(negedge CLK);
    RXD = 1'b1;
    repeat (4) @(negedge CLK);
    chk("glitch_busy_hi", rx_busy, 1);
    repeat (4) @(negedge CLK);
    chk("glitch_cyc", cyc - t0, 10);
    chk("glitch_busy_lo", rx_busy, 0);
    repeat (100) @(negedge CLK);
    chk("glitch_xfer", n_xfer - xb, 0);
    chk("glitch_ferr", n_ferr - fb, 0);

    xb = n_xfer; fb = n_ferr;
    send(8'hA5, 1'b0, 1'b0, t0);
    RXD = 1'b0;
    repeat (30) @(negedge CLK);
    chk("ferr_cnt", n_ferr - fb, 1);
    chk("ferr_lat", ferr_cyc - t0, LAT);
    chk("ferr_xfer", n_xfer - xb, 0);
    chk("ferr_noretrig", rx_busy, 0);
    RXD = 1'b1;
    repeat (20) @(negedge CLK);

    rx_ready = 1'b0;
    xb = n_xfer;
    send(8'h12, 1'b1, 1'b0, t0);
    send(8'h34, 1'b1, 1'b0, t0);
    repeat (2) @(negedge CLK);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 8'h12);
    chk("ovr_flag", rx_overrun, 1);
    rx_ready = 1'b1;
    @(negedge CLK);
    rx_ready = 1'b0;
    chk("ovr_clr_valid", rx_valid, 0);
    chk("ovr_clr_flag", rx_overrun, 0);
    chk("ovr_xfer", n_xfer - xb, 1);
    chk("ovr_xdata", xfer_data, 8'h12);
    rx_ready = 1'b1;
    repeat (5) @(negedge CLK);

    fr = frame(8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      RXD = fr[i];
      repeat (DIV) @(negedge CLK);
    end
    RXD = fr[5];
    repeat (5) @(negedge CLK);
    chk("mid_busy", rx_busy, 1);
    chk("mid_data_old", rx_data, 8'h12);
    #2 RESET = 1'b1;
    #1;
    chk("mid_rst_busy", rx_busy, 0);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_ovr", rx_overrun, 0);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (60) @(negedge CLK);
    xb = n_xfer;
    send(8'h3C, 1'b1, 1'b0, t0);
    repeat (2) @(negedge CLK);
    chk("post_rst_cnt", n_xfer - xb, 1);
    chk("post_rst_data", xfer_data, 8'h3C);
    chk("post_rst_lat", rise_cyc - t0, LAT);

`ifdef UART_RX_PARITY_EN
    xb = n_xfer; pb = n_perr;
    send(8'h07, 1'b1, 1'b1, t0);
    repeat (2) @(negedge CLK);
    chk("par_bad_cnt", n_perr - pb, 1);
    chk("par_bad_xfer", n_xfer - xb, 0);
    xb = n_xfer; pb = n_perr;
    send(8'h07, 1'b1, 1'b0, t0);
    repeat (2) @(negedge CLK);
    chk("par_ok_perr", n_perr - pb, 0);
    chk("par_ok_data", xfer_data, 8'h07);
    chk("par_ok_cnt", n_xfer - xb, 1);
`endif

    for (int k = 0; k < 24; k++) begin
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 5) != 0);
      xb = n_xfer; fb = n_ferr;
      send(b, good, 1'b0, t0);
      if (good) begin
        chk("rand_cnt", n_xfer - xb, 1);
        chk("rand_data", xfer_data, b);
        chk("rand_lat", rise_cyc - t0, LAT);
      end else begin
        chk("rand_ferr", n_ferr - fb, 1);
        chk("rand_noxfer", n_xfer - xb, 0);
      end
      gap = good ? $urandom_range(0, 12) : $urandom_range(2, 12);
      repeat (gap) @(negedge CLK);
    end
    repeat (20) @(negedge CLK);
    chk("end_idle", rx_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
